// File: rtl/bldc_hall_decoder.sv
// Hall sensor decoder for a BLDC motor.
// Synchronizes and debounces the three Hall pins, maps the accepted code to
// one of six electrical sectors and produces the 12-bit angle for the
// commutation block. It also tracks step count, direction and step period.
// Ports:
//   clk, rst_n               system clock, synchronous active-low reset
//   hall_a/b/c               asynchronous Hall pins, code = {a,b,c}
//   err_clr                  one-cycle pulse clearing the sticky error
//   feedback[11:0]           electrical angle (0..4095 = 0..360 deg) plus offset
//   position[31:0]           signed step counter, wraps two's-complement
//   period[23:0]             cycles between the last two same-direction steps
//   dir, step, locked, error direction, step pulse, lock flag, sticky error
module bldc_hall_decoder #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter logic [11:0] ANGLE_OFFSET = 12'd0,
  parameter logic [23:0] TIMEOUT      = 24'hFFFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hall_a,
  input  logic               hall_b,
  input  logic               hall_c,
  input  logic               err_clr,
  output logic [11:0]        feedback,
  output logic signed [31:0] position,
  output logic [23:0]        period,
  output logic               dir,
  output logic               step,
  output logic               locked,
  output logic               error
);

  // Counter must hold DEBOUNCE+1 so the run length can pass the threshold once.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 2);

  typedef enum logic {
    UNLOCKED = 1'b0,
    TRACK    = 1'b1
  } state_t;

  // {valid, sector} for a Hall code; 000 and 111 are invalid.
  function automatic logic [3:0] hall_to_sector(input logic [2:0] code);
    case (code)
      3'b101:  return {1'b1, 3'd0};
      3'b100:  return {1'b1, 3'd1};
      3'b110:  return {1'b1, 3'd2};
      3'b010:  return {1'b1, 3'd3};
      3'b011:  return {1'b1, 3'd4};
      3'b001:  return {1'b1, 3'd5};
      default: return 4'b0000;
    endcase
  endfunction

  // Sector centre angle, 60 deg = 4096/6 counts, rounded.
  function automatic logic [11:0] sector_angle(input logic [2:0] sec);
    case (sec)
      3'd0:    return 12'd0;
      3'd1:    return 12'd683;
      3'd2:    return 12'd1365;
      3'd3:    return 12'd2048;
      3'd4:    return 12'd2731;
      3'd5:    return 12'd3413;
      default: return 12'd0;
    endcase
  endfunction

  logic [2:0]       sync1, sync2, cand, code_db;
  logic [CNT_W-1:0] cnt, run_c;
  logic             accept_c, code_vld;

  state_t             state, state_nxt;
  logic [2:0]         sector, sector_nxt;
  logic [23:0]        pcnt, pcnt_nxt, period_nxt;
  logic               have_step, have_step_nxt;
  logic [11:0]        feedback_nxt;
  logic signed [31:0] position_nxt;
  logic               dir_nxt, step_nxt, locked_nxt, error_nxt, err_evt;
  logic               new_valid, fwd, rev;
  logic [2:0]         new_sec;

  // Two-flop synchronizer for the pin triplet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {hall_a, hall_b, hall_c};
      sync2 <= sync1;
    end
  end

  // Run length of the synchronized code including the current cycle.
  always_comb begin
    run_c = CNT_W'(1);
    if (sync2 == cand) run_c = cnt + CNT_W'(1);
    accept_c = (run_c == CNT_W'(DEBOUNCE));
  end

  // Debounce: a code is accepted exactly once, on its DEBOUNCE-th stable cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand     <= '0;
      cnt      <= '0;
      code_db  <= '0;
      code_vld <= 1'b0;
    end else begin
      cand     <= sync2;
      cnt      <= (run_c > CNT_W'(DEBOUNCE)) ? CNT_W'(DEBOUNCE) : run_c;
      code_vld <= accept_c;
      if (accept_c) code_db <= sync2;
    end
  end

  // Next-state and output logic for the lock/track FSM.
  always_comb begin
    state_nxt     = state;
    sector_nxt    = sector;
    feedback_nxt  = feedback;
    position_nxt  = position;
    period_nxt    = period;
    dir_nxt       = dir;
    step_nxt      = 1'b0;
    locked_nxt    = locked;
    have_step_nxt = have_step;
    err_evt       = 1'b0;
    pcnt_nxt      = (pcnt == TIMEOUT) ? pcnt : pcnt + 24'd1;
    {new_valid, new_sec} = hall_to_sector(code_db);
    fwd = (new_sec == ((sector == 3'd5) ? 3'd0 : sector + 3'd1));
    rev = (new_sec == ((sector == 3'd0) ? 3'd5 : sector - 3'd1));

    // Motor considered stopped once the interval counter saturates.
    if (pcnt == TIMEOUT) period_nxt = '0;

    if (code_vld) begin
      case (state)
        UNLOCKED: begin
          if (new_valid) begin
            state_nxt     = TRACK;
            sector_nxt    = new_sec;
            feedback_nxt  = sector_angle(new_sec) + ANGLE_OFFSET;
            locked_nxt    = 1'b1;
            have_step_nxt = 1'b0;
          end else begin
            err_evt = 1'b1;
          end
        end
        TRACK: begin
          if (!new_valid) begin
            err_evt = 1'b1;
          end else if (new_sec != sector) begin
            sector_nxt   = new_sec;
            feedback_nxt = sector_angle(new_sec) + ANGLE_OFFSET;
            pcnt_nxt     = '0;
            if (fwd || rev) begin
              step_nxt      = 1'b1;
              dir_nxt       = fwd;
              position_nxt  = fwd ? position + 32'sd1 : position - 32'sd1;
              have_step_nxt = 1'b1;
              // Only a same-direction step with a live counter gives a period.
              if (have_step && (fwd == dir) && (pcnt != TIMEOUT)) begin
                period_nxt = pcnt + 24'd1;
              end else begin
                period_nxt = '0;
              end
            end else begin
              // Sector skip: follow the angle but drop the period reference.
              err_evt       = 1'b1;
              period_nxt    = '0;
              have_step_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end

    // A new error event overrides a simultaneous clear.
    error_nxt = err_evt | (error & ~err_clr);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      sector    <= '0;
      pcnt      <= '0;
      have_step <= 1'b0;
      feedback  <= ANGLE_OFFSET;
      position  <= '0;
      period    <= '0;
      dir       <= 1'b1;
      step      <= 1'b0;
      locked    <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      sector    <= sector_nxt;
      pcnt      <= pcnt_nxt;
      have_step <= have_step_nxt;
      feedback  <= feedback_nxt;
      position  <= position_nxt;
      period    <= period_nxt;
      dir       <= dir_nxt;
      step      <= step_nxt;
      locked    <= locked_nxt;
      error     <= error_nxt;
    end
  end

endmodule

// File: tb/tb_bldc_hall_decoder.sv
// Bench for bldc_hall_decoder: directed scenarios followed by random Hall
// sequences, checked against an event-level model of accepted codes.
module tb_bldc_hall_decoder;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 5000;
  localparam int unsigned OFS = 3000;

  logic clk = 1'b0;
  logic rst_n, hall_a, hall_b, hall_c, err_clr;
  logic [11:0]        feedback, fb2;
  logic signed [31:0] position, pos2;
  logic [23:0]        period, per2;
  logic dir, step, locked, error;
  logic dir2, step2, locked2, error2;

  bldc_hall_decoder #(.DEBOUNCE(DEB), .ANGLE_OFFSET(12'd0), .TIMEOUT(24'(TMO))) dut (
    .clk(clk), .rst_n(rst_n), .hall_a(hall_a), .hall_b(hall_b), .hall_c(hall_c),
    .err_clr(err_clr), .feedback(feedback), .position(position), .period(period),
    .dir(dir), .step(step), .locked(locked), .error(error));

  bldc_hall_decoder #(.DEBOUNCE(DEB), .ANGLE_OFFSET(12'(OFS)), .TIMEOUT(24'(TMO))) dut_ofs (
    .clk(clk), .rst_n(rst_n), .hall_a(hall_a), .hall_b(hall_b), .hall_c(hall_c),
    .err_clr(err_clr), .feedback(fb2), .position(pos2), .period(per2),
    .dir(dir2), .step(step2), .locked(locked2), .error(error2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  int step_cnt = 0;
  int step_base = 0;
  logic [2:0] pin;
  logic [2:0] codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  // Model state, updated per accepted code with the edge at which it lands.
  bit     m_locked, m_dir, m_have;
  int     m_sec, m_pos, m_steps;
  longint m_period, m_pclr, m_err_edge, m_clr_edge;

  always @(negedge clk) if (step === 1'b1) step_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int angle(input int sec);
    return (sec * 4096 + 3) / 6;
  endfunction

  function automatic int sector_of(input logic [2:0] code);
    for (int i = 0; i < 6; i++) if (codes[i] == code) return i;
    return -1;
  endfunction

  function automatic void model_accept(input logic [2:0] code, input longint edge_t);
    int s, d;
    bit up;
    s = sector_of(code);
    if (!m_locked) begin
      if (s < 0) m_err_edge = edge_t;
      else begin
        m_locked = 1;
        m_sec    = s;
        m_have   = 0;
      end
    end else if (s < 0) begin
      m_err_edge = edge_t;
    end else if (s != m_sec) begin
      d = (s - m_sec + 6) % 6;
      if (d == 1 || d == 5) begin
        up = (d == 1);
        m_period = (m_have && up == m_dir && (edge_t - m_pclr) <= TMO) ? edge_t - m_pclr : 0;
        m_pos   = up ? m_pos + 1 : m_pos - 1;
        m_dir   = up;
        m_have  = 1;
        m_steps++;
      end else begin
        m_err_edge = edge_t;
        m_period   = 0;
        m_have     = 0;
      end
      m_sec  = s;
      m_pclr = edge_t;
    end
  endfunction

  task automatic check_all(input string tag);
    int fb;
    longint exp_per;
    fb      = m_locked ? angle(m_sec) : 0;
    exp_per = ((cyc - m_pclr) > TMO) ? 0 : m_period;
    chk({tag, "/feedback"}, 32'(feedback), 32'(fb));
    chk({tag, "/feedback_ofs"}, 32'(fb2), 32'((fb + OFS) % 4096));
    chk({tag, "/position"}, position, 32'(m_pos));
    chk({tag, "/period"}, 32'(period), 32'(exp_per));
    chk({tag, "/dir"}, 32'(dir), 32'(m_dir));
    chk({tag, "/step"}, 32'(step), 32'd0);
    chk({tag, "/locked"}, 32'(locked), 32'(m_locked));
    chk({tag, "/error"}, 32'(error), 32'(m_err_edge >= 0 && m_err_edge >= m_clr_edge));
    chk({tag, "/steps"}, 32'(step_cnt - step_base), 32'(m_steps));
  endtask

  // Drive a code for 'hold' cycles; optional err_clr on cycle clr_at.
  task automatic seg(input logic [2:0] code, input int hold, input int clr_at, input string tag);
    longint start;
    start = cyc;
    {hall_a, hall_b, hall_c} = code;
    pin = code;
    if (hold >= DEB) model_accept(code, start + DEB + 3);
    for (int i = 1; i <= hold; i++) begin
      err_clr = (i == clr_at);
      tick();
    end
    err_clr = 1'b0;
    if (clr_at > 0 && clr_at <= hold) m_clr_edge = start + clr_at;
    if (hold >= DEB + 4) check_all(tag);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_clr_edge = cyc;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    chk({tag, "/rst_feedback"}, 32'(feedback), 32'd0);
    chk({tag, "/rst_feedback_ofs"}, 32'(fb2), 32'(OFS));
    chk({tag, "/rst_position"}, position, 32'd0);
    chk({tag, "/rst_period"}, 32'(period), 32'd0);
    chk({tag, "/rst_dir"}, 32'(dir), 32'd1);
    chk({tag, "/rst_step"}, 32'(step), 32'd0);
    chk({tag, "/rst_locked"}, 32'(locked), 32'd0);
    chk({tag, "/rst_error"}, 32'(error), 32'd0);
    tick();
    tick();
    step_base  = step_cnt;
    rst_n      = 1'b1;
    m_locked   = 0; m_dir = 1; m_have = 0;
    m_sec      = 0; m_pos = 0; m_steps = 0; m_period = 0;
    m_pclr     = cyc;
    m_err_edge = -1;
    m_clr_edge = -1;
  endtask

  initial begin
    logic [2:0] code, g, back;
    int r, hold;
    rst_n = 1'b0; err_clr = 1'b0;
    {hall_a, hall_b, hall_c} = 3'b101;
    pin = 3'b101;
    do_reset("init");

    // Lock on 101 with exact latency.
    seg(3'b101, DEB + 2, 0, "");
    chk("t1_locked_early", 32'(locked), 32'd0);
    tick();
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_feedback", 32'(feedback), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check_all("t1");

    // Forward revolution at 1000-cycle spacing.
    seg(3'b100, 1000, 0, "t2_s1");
    seg(3'b110, 1000, 0, "t2_s2");
    chk("t2_period", 32'(period), 32'd1000);
    seg(3'b010, 1000, 0, "t2_s3");
    seg(3'b011, 1000, 0, "t2_s4");
    seg(3'b001, 1000, 0, "t2_s5");
    seg(3'b101, 1000, 0, "t2_s6");
    chk("t2_position", position, 32'd6);
    chk("t2_feedback", 32'(feedback), 32'd0);
    chk("t2_dir", 32'(dir), 32'd1);
    chk("t2_steps", 32'(step_cnt - step_base), 32'd6);

    // Reversal.
    seg(3'b001, 1000, 0, "t3");
    chk("t3_feedback", 32'(feedback), 32'd3413);
    chk("t3_position", position, 32'd5);
    chk("t3_period", 32'(period), 32'd0);

    // Glitch shorter than the debounce window.
    seg(3'b101, DEB - 1, 0, "");
    seg(3'b001, 200, 0, "t4");
    chk("t4_position", position, 32'd5);

    // Invalid codes, skip, error clear and clear/event collision.
    seg(3'b111, 100, 0, "t5_111");
    chk("t5_err", 32'(error), 32'd1);
    seg(3'b000, 100, 0, "t5_000");
    chk("t5_fb_held", 32'(feedback), 32'd3413);
    seg(3'b101, 100, 0, "t5_fwd");
    clr_err();
    chk("t5_cleared", 32'(error), 32'd0);
    seg(3'b110, 100, 0, "t5_skip");
    chk("t5_skip_fb", 32'(feedback), 32'd1365);
    chk("t5_skip_pos", position, 32'd6);
    clr_err();
    seg(3'b111, DEB + 10, DEB + 3, "t5_collide");
    chk("t5_collide_err", 32'(error), 32'd1);
    clr_err();
    chk("t5_cleared2", 32'(error), 32'd0);

    // Period boundary and timeout.
    seg(3'b110, 50, 0, "t6_back");
    seg(3'b010, int'(TMO), 0, "t6_a");
    seg(3'b011, 100, 0, "t6_b");
    chk("t6_period_edge", 32'(period), 32'(TMO));
    seg(3'b001, int'(TMO) + 100, 0, "t6_c");
    chk("t6_timeout", 32'(period), 32'd0);
    seg(3'b101, 50, 0, "t6_d");
    chk("t6_late_step", 32'(period), 32'd0);

    // Reset in the middle of a pending change, then relock.
    seg(3'b100, 2, 0, "");
    do_reset("t6_rst");
    seg(3'b100, 30, 0, "t6_relock");
    chk("t6_relock_fb", 32'(feedback), 32'd683);

    // Random Hall traffic.
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(99));
      if ($urandom_range(29) == 0) hold = int'($urandom_range(4900, 5200));
      else if ($urandom_range(9) == 0) hold = int'($urandom_range(DEB, DEB + 3));
      else hold = int'($urandom_range(DEB + 4, 300));
      if (r < 65) begin
        code = codes[(m_sec + (($urandom_range(3) != 0) ? 1 : 5)) % 6];
        seg(code, hold, 0, "rnd_step");
      end else if (r < 78) begin
        back = pin;
        g = 3'($urandom_range(7));
        while (g == pin) g = 3'($urandom_range(7));
        seg(g, int'($urandom_range(1, DEB - 1)), 0, "");
        seg(back, hold, 0, "rnd_glitch");
      end else if (r < 88) begin
        code = codes[(m_sec + int'($urandom_range(2, 4))) % 6];
        seg(code, hold, 0, "rnd_skip");
      end else begin
        code = ($urandom_range(1) == 0) ? 3'b000 : 3'b111;
        if (code == pin) code = ~code;
        seg(code, hold, 0, "rnd_invalid");
      end
      if (hold >= DEB + 4 && $urandom_range(4) == 0) begin
        clr_err();
        check_all("rnd_clr");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
